// File: rtl/decode_code_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_code_stage
//  Purpose  : Decode-side pipeline stage. Classifies each fetched instruction
//             by its major opcode into a one-hot class code and holds the
//             classified entry in a two-entry skid buffer (main + skid).
//             This keeps in_ready purely registered. Also keeps a saturating
//             count of illegal entries handed downstream.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   rising-edge clock
//    reset         in   1   synchronous active-high reset
//    flush         in   1   discard all buffered entries and the offered one
//    in_valid      in   1   upstream entry valid
//    in_ready      out  1   stage can accept (registered, = !skid_valid)
//    in_instr      in  32   fetched instruction word
//    in_pc         in  32   address of in_instr
//    out_valid     out  1   entry available downstream
//    out_ready     in   1   downstream accepts the entry
//    out_instr     out 32   registered instruction
//    out_pc        out 32   registered pc
//    out_code      out 10   one-hot instruction class
//    out_illegal   out  1   opcode matched no class
//    illegal_count out  8   saturating count of illegal entries consumed
// ============================================================================
module decode_code_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [9:0]  out_code,
  output logic        out_illegal,
  output logic [7:0]  illegal_count
);

  // Major opcodes, one per class bit
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // --------------------------------------------------------------------------
  // Buffer registers
  // --------------------------------------------------------------------------
  logic        main_valid;
  logic [31:0] main_instr;
  logic [31:0] main_pc;
  logic [9:0]  main_code;
  logic        main_illegal;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [9:0]  skid_code;
  logic        skid_illegal;

  logic [7:0]  count;

  // --------------------------------------------------------------------------
  // Capture-time classification of the offered instruction
  // --------------------------------------------------------------------------
  logic [9:0] cap_code;
  logic       cap_illegal;

  always_comb begin
    cap_code = 10'b0;
    case (in_instr[6:0])
      OP_JAL:    cap_code = 10'b00_0000_0001;
      OP_JALR:   cap_code = 10'b00_0000_0010;
      OP_LUI:    cap_code = 10'b00_0000_0100;
      OP_AUIPC:  cap_code = 10'b00_0000_1000;
      OP_BRANCH: cap_code = 10'b00_0001_0000;
      OP_REG:    cap_code = 10'b00_0010_0000;
      OP_STORE:  cap_code = 10'b00_0100_0000;
      OP_IMM:    cap_code = 10'b00_1000_0000;
      OP_LOAD:   cap_code = 10'b01_0000_0000;
      OP_SYSTEM: cap_code = 10'b10_0000_0000;
      default:   cap_code = 10'b0;
    endcase
    cap_illegal = (cap_code == 10'b0);
  end

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic accept;
  logic consume;
  logic load_main_from_in;
  logic load_main_from_skid;
  logic load_skid;

  always_comb begin
    accept  = in_valid & in_ready;
    consume = main_valid & out_ready;
    // Skid drains into main whenever main is taken; accept cannot coincide
    // because in_ready is low while skid holds an entry.
    load_main_from_skid = skid_valid & consume;
    // accept implies skid is empty, so only main's state matters here.
    load_main_from_in   = accept & (~main_valid | consume);
    load_skid           = accept & main_valid & ~consume;
  end

  // --------------------------------------------------------------------------
  // Main (output) register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid   <= 1'b0;
      main_instr   <= 32'b0;
      main_pc      <= 32'b0;
      main_code    <= 10'b0;
      main_illegal <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (load_main_from_skid) begin
      main_valid   <= 1'b1;
      main_instr   <= skid_instr;
      main_pc      <= skid_pc;
      main_code    <= skid_code;
      main_illegal <= skid_illegal;
    end else if (load_main_from_in) begin
      main_valid   <= 1'b1;
      main_instr   <= in_instr;
      main_pc      <= in_pc;
      main_code    <= cap_code;
      main_illegal <= cap_illegal;
    end else if (consume) begin
      main_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Skid register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid   <= 1'b0;
      skid_instr   <= 32'b0;
      skid_pc      <= 32'b0;
      skid_code    <= 10'b0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (load_main_from_skid) begin
      skid_valid <= 1'b0;
    end else if (load_skid) begin
      skid_valid   <= 1'b1;
      skid_instr   <= in_instr;
      skid_pc      <= in_pc;
      skid_code    <= cap_code;
      skid_illegal <= cap_illegal;
    end
  end

  // --------------------------------------------------------------------------
  // Illegal-entry counter; a flush cycle leaves it untouched.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'b0;
    end else if (!flush && consume && main_illegal && (count != COUNT_MAX)) begin
      count <= count + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all come straight from registers
  // --------------------------------------------------------------------------
  assign in_ready      = ~skid_valid;
  assign out_valid     = main_valid;
  assign out_instr     = main_instr;
  assign out_pc        = main_pc;
  assign out_code      = main_code;
  assign out_illegal   = main_illegal;
  assign illegal_count = count;

endmodule
`default_nettype wire

// File: tb/tb_decode_code_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_code_stage
//  Purpose  : Self-checking bench for decode_code_stage. A queue holds the
//             entries the stage should be holding, in order; the head is
//             compared with the outputs every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_code_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'b0;
  logic [31:0] in_pc = 32'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [9:0]  out_code;
  logic        out_illegal;
  logic [7:0]  illegal_count;

  decode_code_stage dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_code      (out_code),
    .out_illegal   (out_illegal),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  code;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   exp_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [9:0] class_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b1101111: class_of = 10'd1 << 0;
      7'b1100111: class_of = 10'd1 << 1;
      7'b0110111: class_of = 10'd1 << 2;
      7'b0010111: class_of = 10'd1 << 3;
      7'b1100011: class_of = 10'd1 << 4;
      7'b0110011: class_of = 10'd1 << 5;
      7'b0100011: class_of = 10'd1 << 6;
      7'b0010011: class_of = 10'd1 << 7;
      7'b0000011: class_of = 10'd1 << 8;
      7'b1110011: class_of = 10'd1 << 9;
      default:    class_of = 10'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model (at negedge), then clock once and
  // update the model with what the stage should have done at that edge.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy);
    ent_t e;
    bit   acc;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2)});
    check("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
    check("illegal_count", {24'b0, illegal_count}, exp_cnt);
    if (q.size() > 0) begin
      check("out_code", {22'b0, out_code}, {22'b0, q[0].code});
      check("out_illegal", {31'b0, out_illegal}, {31'b0, q[0].ill});
      check("out_instr", out_instr, q[0].instr);
      check("out_pc", out_pc, q[0].pc);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      if (q.size() > 0 && ordy) begin
        e = q.pop_front();
        if (e.ill && exp_cnt < 255) exp_cnt++;
      end
      if (acc) begin
        e.code  = class_of(ins);
        e.ill   = (e.code == 10'b0);
        e.instr = ins;
        e.pc    = pc;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, 32'b0, 32'b0, ordy);
  endtask

  initial begin
    // Reset, then release: in_ready must be 1 immediately
    #1;
    step(1'b1, 1'b0, 1'b0, 32'b0, 32'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000006F, 32'h4, 1'b0);
    @(negedge clk);
    check("rst_out_code", {22'b0, out_code}, 32'h0);
    check("rst_out_illegal", {31'b0, out_illegal}, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single JAL, one-cycle latency
    step(1'b0, 1'b0, 1'b1, 32'h0000006F, 32'h100, 1'b1);
    @(negedge clk);
    check("jal_valid", {31'b0, out_valid}, 32'h1);
    check("jal_code", {22'b0, out_code}, 32'h001);
    check("jal_pc", out_pc, 32'h100);
    @(posedge clk); #1;
    idle(1'b1);

    // Back-to-back with out_ready high
    step(1'b0, 1'b0, 1'b1, 32'h00000013, 32'h200, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h00000073, 32'h204, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h00000037, 32'h208, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // All class opcodes plus one illegal, steady stream
    step(1'b0, 1'b0, 1'b1, 32'h00000067, 32'h300, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h00000017, 32'h304, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h00000063, 32'h308, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h00000033, 32'h30C, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h00000023, 32'h310, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h00000003, 32'h314, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0000000F, 32'h318, 1'b1);
    idle(1'b1);
    @(negedge clk);
    check("illegal_count_1", {24'b0, illegal_count}, 32'd1);
    @(posedge clk); #1;

    // Backpressure: three offered, two taken, held stable, drained in order
    step(1'b0, 1'b0, 1'b1, 32'h00000013, 32'h400, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00000033, 32'h404, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00000003, 32'h408, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00000003, 32'h408, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Mixed ready pattern
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b0, 1'(i % 3 != 2), 32'h00000023 + (i % 2) * 32'h40,
           32'h500 + 4 * i, 1'(i % 2));
    idle(1'b1);
    idle(1'b1);

    // Flush with both entries full; count must not change
    step(1'b0, 1'b0, 1'b1, 32'h0000000F, 32'h600, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00000013, 32'h604, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h00000013, 32'h608, 1'b0);
    @(negedge clk);
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    check("flush_ready", {31'b0, in_ready}, 32'h1);
    check("flush_count", {24'b0, illegal_count}, 32'd1);
    @(posedge clk); #1;

    // 300 illegal deliveries saturate at 255
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b0, 1'b1, 32'h0000000F, 32'h1000 + 4 * i, 1'b1);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    check("count_sat", {24'b0, illegal_count}, 32'd255);
    @(posedge clk); #1;

    // Reset with both entries full and an entry offered
    step(1'b0, 1'b0, 1'b1, 32'h00000013, 32'h700, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00000033, 32'h704, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000006F, 32'h708, 1'b0);
    @(negedge clk);
    check("rst2_valid", {31'b0, out_valid}, 32'h0);
    check("rst2_code", {22'b0, out_code}, 32'h0);
    check("rst2_count", {24'b0, illegal_count}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1'b1);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
